logicnet_lut_layer: RTL and testbench

LOGICNET_LUT_LAYER -- requirements
Module: logicnet_lut_layer

---
 rtl/logicnet_lut_layer.sv | 126 ++++++++++++
 tb/tb_logicnet_lut_layer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logicnet_lut_layer.sv
// LogicNet LUT layer: per-neuron distributed-RAM truth tables behind a
// two-stage valid/ready pipeline, with a drain-then-program config mode.
module logicnet_lut_layer #(
    parameter int NUM_NEURONS = 4,
    parameter int FANIN_BITS  = 8,
    parameter int OUT_BITS    = 1,
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_NEURONS*FANIN_BITS-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            cfg_mode,
    input  logic                            cfg_we,
    input  logic [NW-1:0]                   cfg_neuron,
    input  logic [FANIN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_data,
    output logic                            cfg_active
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CFG   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                              s1_valid;
    logic [NUM_NEURONS*FANIN_BITS-1:0] s1_data;
    logic                              s2_valid;
    logic [NUM_NEURONS*OUT_BITS-1:0]   s2_data;
    logic [NUM_NEURONS*OUT_BITS-1:0]   lut_out;

    logic out_fire;
    logic s1_adv;
    logic in_fire;
    logic cfg_wr;

    assign out_fire = s2_valid && out_ready;
    assign s1_adv   = s1_valid && (!s2_valid || out_fire);
    assign in_fire  = in_valid && in_ready;
    // A write on a reset cycle is discarded along with in-flight data.
    assign cfg_wr   = !rst && (state == CFG) && cfg_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (cfg_mode) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!cfg_mode) begin
                    state_nxt = RUN;
                end else if (!s1_valid && !s2_valid) begin
                    state_nxt = CFG;
                end
            end
            CFG: begin
                if (!cfg_mode) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        in_ready   = (state == RUN) && !cfg_mode && (!s1_valid || s1_adv);
        cfg_active = (state == CFG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_data  <= lut_out;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_neuron
        logic [OUT_BITS-1:0] tbl [2**FANIN_BITS];
        logic                we;

        // Out-of-range neuron indices match no table and are dropped.
        assign we = cfg_wr && (cfg_neuron == NW'(k));

        always_ff @(posedge clk) begin
            if (we) tbl[cfg_addr] <= cfg_data;
        end

        assign lut_out[k*OUT_BITS +: OUT_BITS] =
            tbl[s1_data[k*FANIN_BITS +: FANIN_BITS]];
    end

    assign out_data  = s2_data;
    assign out_valid = s2_valid;

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Self-checking bench for logicnet_lut_layer: truth-table model plus
// directed handshake, backpressure, config and reset scenarios.
module tb_logicnet_lut_layer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        cfg_mode = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_neuron = '0;
    logic [7:0]  cfg_addr = '0;
    logic [0:0]  cfg_data = '0;
    logic        cfg_active;

    logicnet_lut_layer #(
        .NUM_NEURONS(4),
        .FANIN_BITS (8),
        .OUT_BITS   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_mode  (cfg_mode),
        .cfg_we    (cfg_we),
        .cfg_neuron(cfg_neuron),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_active(cfg_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    bit lat_check = 1'b0;
    bit stalled = 1'b0;
    logic [3:0] held;
    logic tbl_m [4][256];
    logic [3:0] exp_q [$];
    int cyc_q [$];

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic f0(input logic [7:0] a);
        return a[6] | (a[7] & a[4] & a[1]);
    endfunction

    function automatic logic [3:0] model_vec(input logic [31:0] d);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = tbl_m[k][d[k*8 +: 8]];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted input yields one output, in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cyc_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk(out_valid && out_data == held, "stall_hold",
                    {out_valid, out_data}, {1'b1, held});
            if (out_valid) begin
                chk(exp_q.size() > 0, "spurious_out", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    chk(out_data == exp_q[0], "model_out", out_data, exp_q[0]);
                    if (out_ready) begin
                        if (lat_check)
                            chk(cyc - cyc_q[0] == 2, "latency",
                                cyc - cyc_q[0], 2);
                        void'(exp_q.pop_front());
                        void'(cyc_q.pop_front());
                        pops++;
                    end
                end
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_vec(in_data));
                cyc_q.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [31:0] d);
        int n;
        in_data = d;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(in_ready, "send_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_lit(input logic [3:0] lit, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(out_valid && out_data == lit, name, {out_valid, out_data}, {1'b1, lit});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
    endtask

    task automatic cfg_write(input logic [1:0] nn, input logic [7:0] a,
                             input logic d, input bit in_cfg);
        cfg_neuron = nn;
        cfg_addr = a;
        cfg_data = d;
        cfg_we = 1'b1;
        @(posedge clk);
        if (in_cfg) tbl_m[nn][a] = d;
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_cfg(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_active && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(cfg_active, "cfg_enter", cfg_active, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic leave_cfg();
        cfg_mode = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk(!cfg_active, "cfg_exit", cfg_active, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input bit lat);
        int p0;
        p0 = pops;
        lat_check = lat;
        for (int i = 0; i < 256; i++) begin
            in_data = {4{8'(i)}};
            in_valid = 1'b1;
            @(negedge clk);
            chk(in_ready, "stream_ready", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        lat_check = 1'b0;
        chk(pops - p0 == 256, "stream_count", pops - p0, 256);
    endtask

    initial begin
        int p0;
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 256; a++) tbl_m[k][a] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(!out_valid, "rst_out_valid", out_valid, 0);
        chk(out_data == 4'h0, "rst_out_data", out_data, 0);
        chk(!cfg_active, "rst_cfg_active", cfg_active, 0);
        chk(in_ready, "rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        cfg_mode = 1'b1;
        wait_cfg(4);
        for (int a = 0; a < 256; a++) begin
            cfg_write(2'd0, 8'(a), f0(8'(a)), 1'b1);
            for (int k = 1; k < 4; k++)
                cfg_write(2'(k), 8'(a), ^(8'(a)), 1'b1);
        end
        leave_cfg();

        chk(model_vec(32'h00000000) == 4'h0, "model_pin_00", model_vec(32'h0), 4'h0);
        chk(model_vec(32'h92929292) == 4'hF, "model_pin_92", model_vec(32'h92929292), 4'hF);
        chk(model_vec(32'h07070707) == 4'hE, "model_pin_07", model_vec(32'h07070707), 4'hE);

        send(32'h07070707);
        expect_lit(4'hE, "lit_07");
        send(32'h92929292);
        expect_lit(4'hF, "lit_92");

        stream(1'b1);

        // Backpressure: two entries fill the pipe, the third must wait.
        p0 = pops;
        out_ready = 1'b0;
        send(32'h07070707);
        send(32'h92929292);
        in_data = 32'h40404040;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk(!in_ready, "bp_in_ready", in_ready, 0);
            chk(out_valid && out_data == 4'hE, "bp_hold",
                {out_valid, out_data}, 5'h1E);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk(in_ready, "bp_release", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk(pops - p0 == 3, "bp_count", pops - p0, 3);

        // Config request with two transactions in flight.
        p0 = pops;
        in_valid = 1'b1;
        in_data = 32'h07070707;
        @(posedge clk);
        #1;
        in_data = 32'h92929292;
        @(posedge clk);
        #1;
        cfg_mode = 1'b1;
        in_data = 32'h40404040;
        @(negedge clk);
        chk(!in_ready, "cfg_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_cfg(4);
        chk(pops - p0 == 2, "cfg_drained", pops - p0, 2);
        cfg_write(2'd2, 8'h5A, 1'b1, 1'b1);
        leave_cfg();
        send(32'h5A5A5A5A);
        expect_lit(4'h5, "lit_5a_after_cfg");

        // Write attempted in RUN must be ignored.
        cfg_write(2'd1, 8'h00, 1'b1, 1'b0);
        send(32'h00000000);
        expect_lit(4'h0, "lit_run_write_ignored");

        // Reset with a full, stalled pipeline.
        out_ready = 1'b0;
        send(32'h07070707);
        send(32'h92929292);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk(!out_valid, "rst2_out_valid", out_valid, 0);
        chk(out_data == 4'h0, "rst2_out_data", out_data, 0);
        chk(!cfg_active, "rst2_cfg_active", cfg_active, 0);
        chk(in_ready, "rst2_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;

        stream(1'b1);
        send(32'h5A5A5A5A);
        expect_lit(4'h5, "lit_5a_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
